// File: rtl/game_controller_if.sv
// Updater-facing bus of the Sudoku game sequencer.
//   master (game_controller): drives state, cursor index, map choice, gated
//                             button pulses, soft_reset, elapsed_seconds;
//                             reads visibilities and strikes.
//   slave  (board updater)  : the mirror view.
interface game_controller_if;
   logic [80:0] visibilities;
   logic [1:0]  strikes;
   logic [2:0]  current_state;
   logic [6:0]  index;
   logic [1:0]  map_select;
   logic        up_pulse;
   logic        down_pulse;
   logic        a_pulse;
   logic        b_pulse;
   logic        soft_reset;
   logic [9:0]  elapsed_seconds;

   modport master (
      input  visibilities, strikes,
      output current_state, index, map_select,
             up_pulse, down_pulse, a_pulse, b_pulse,
             soft_reset, elapsed_seconds
   );

   modport slave (
      output visibilities, strikes,
      input  current_state, index, map_select,
             up_pulse, down_pulse, a_pulse, b_pulse,
             soft_reset, elapsed_seconds
   );
endinterface

// File: rtl/game_controller.sv
// Game sequencer for the Sudoku core: game FSM, board cursor, button edge
// detection, gated pulses to the board updater and win/loss decision.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   up_in .. b_in       synchronized, debounced button levels
//   bus (master)        updater bus, see game_controller_if
//
// Parameters:
//   LOAD_CYCLES (1..15) cycles spent in CARREGANDO
//   CLK_HZ              clock frequency, only used by the play timer
//
// Build option: define GAME_TIMER_EN to build the play-time counter;
// otherwise elapsed_seconds is tied to zero.
//
// state               | meaning
// --------------------+----------------------------------------------
// INICIO        000   | idle, waiting for a
// ESCOLHER_MAPA 001   | up/down choose map, a starts loading
// CARREGANDO    010   | map ROM + updater load, LOAD_CYCLES cycles
// PERCORRER_TAB 011   | cursor moves over the board
// PERCORRER_NUM 100   | cell selected, pulses forwarded to updater
// VITORIA       101   | all cells revealed, a returns to INICIO
// DERROTA       110   | three strikes, a returns to INICIO
module game_controller #(
   parameter int LOAD_CYCLES = 2,
   parameter int CLK_HZ      = 50_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic up_in,
   input  logic down_in,
   input  logic left_in,
   input  logic right_in,
   input  logic a_in,
   input  logic b_in,
   game_controller_if.master bus
);

   typedef enum logic [2:0] {
      INICIO              = 3'b000,
      ESCOLHER_MAPA       = 3'b001,
      CARREGANDO          = 3'b010,
      PERCORRER_TABULEIRO = 3'b011,
      PERCORRER_NUMEROS   = 3'b100,
      VITORIA             = 3'b101,
      DERROTA             = 3'b110
   } state_t;

   localparam logic [3:0] LOAD_LAST = 4'(LOAD_CYCLES - 1);

   state_t     state, state_next;
   logic [3:0] row, row_next;
   logic [3:0] col, col_next;
   logic [6:0] index_q, index_next;
   logic [1:0] map_sel, map_next;
   logic [3:0] load_cnt, load_next;
   logic       soft_q, soft_next;

   logic prev_up, prev_down, prev_left, prev_right, prev_a, prev_b;
   logic rise_up, rise_down, rise_left, rise_right, rise_a, rise_b;
   logic in_numeros;
   logic game_over, lost;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_up    <= 1'b0;
         prev_down  <= 1'b0;
         prev_left  <= 1'b0;
         prev_right <= 1'b0;
         prev_a     <= 1'b0;
         prev_b     <= 1'b0;
      end else begin
         prev_up    <= up_in;
         prev_down  <= down_in;
         prev_left  <= left_in;
         prev_right <= right_in;
         prev_a     <= a_in;
         prev_b     <= b_in;
      end
   end

   assign rise_up    = up_in    & ~prev_up;
   assign rise_down  = down_in  & ~prev_down;
   assign rise_left  = left_in  & ~prev_left;
   assign rise_right = right_in & ~prev_right;
   assign rise_a     = a_in     & ~prev_a;
   assign rise_b     = b_in     & ~prev_b;

   // Combinational so the updater acts on the same edge as the FSM.
   assign in_numeros     = (state == PERCORRER_NUMEROS);
   assign bus.up_pulse   = rise_up   & in_numeros;
   assign bus.down_pulse = rise_down & in_numeros;
   assign bus.a_pulse    = rise_a    & in_numeros;
   assign bus.b_pulse    = rise_b    & in_numeros;

   // Loss outranks win if both happen together.
   assign lost      = (bus.strikes == 2'd3);
   assign game_over = lost | (&bus.visibilities);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= INICIO;
         row      <= 4'd0;
         col      <= 4'd0;
         index_q  <= 7'd0;
         map_sel  <= 2'd0;
         load_cnt <= 4'd0;
         soft_q   <= 1'b0;
      end else begin
         state    <= state_next;
         row      <= row_next;
         col      <= col_next;
         index_q  <= index_next;
         map_sel  <= map_next;
         load_cnt <= load_next;
         soft_q   <= soft_next;
      end
   end

   always_comb begin
      state_next = state;
      row_next   = row;
      col_next   = col;
      map_next   = map_sel;
      load_next  = load_cnt;
      soft_next  = 1'b0;

      case (state)
         INICIO: begin
            if (rise_a) state_next = ESCOLHER_MAPA;
         end

         ESCOLHER_MAPA: begin
            if (rise_up)        map_next = map_sel + 2'd1;
            else if (rise_down) map_next = map_sel - 2'd1;
            if (rise_a) begin
               state_next = CARREGANDO;
               load_next  = 4'd0;
            end
         end

         CARREGANDO: begin
            if (load_cnt == LOAD_LAST) begin
               state_next = PERCORRER_TABULEIRO;
               row_next   = 4'd0;
               col_next   = 4'd0;
            end else begin
               load_next = load_cnt + 4'd1;
            end
         end

         PERCORRER_TABULEIRO: begin
            if (game_over) begin
               state_next = lost ? DERROTA : VITORIA;
            end else if (rise_up) begin
               row_next = (row == 4'd0) ? 4'd8 : row - 4'd1;
            end else if (rise_down) begin
               row_next = (row == 4'd8) ? 4'd0 : row + 4'd1;
            end else if (rise_left) begin
               col_next = (col == 4'd0) ? 4'd8 : col - 4'd1;
            end else if (rise_right) begin
               col_next = (col == 4'd8) ? 4'd0 : col + 4'd1;
            end else if (rise_a && !bus.visibilities[index_q]) begin
               state_next = PERCORRER_NUMEROS;
            end
         end

         PERCORRER_NUMEROS: begin
            if (game_over) begin
               state_next = lost ? DERROTA : VITORIA;
            end else if (rise_a || rise_b) begin
               state_next = PERCORRER_TABULEIRO;
            end
         end

         VITORIA, DERROTA: begin
            if (rise_a) begin
               state_next = INICIO;
               soft_next  = 1'b1;
            end
         end

         default: state_next = INICIO;
      endcase

      index_next = 7'(row_next) * 7'd9 + 7'(col_next);
   end

   assign bus.current_state = state;
   assign bus.index         = index_q;
   assign bus.map_select    = map_sel;
   assign bus.soft_reset    = soft_q;

`ifdef GAME_TIMER_EN
   localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0] PRESCALE_LAST = PW'(CLK_HZ - 1);

   logic [PW-1:0] prescale;
   logic [9:0]    seconds;
   logic          playing;

   assign playing = (state == PERCORRER_TABULEIRO) || (state == PERCORRER_NUMEROS);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prescale <= '0;
         seconds  <= 10'd0;
      end else if (state != CARREGANDO && state_next == CARREGANDO) begin
         prescale <= '0;
         seconds  <= 10'd0;
      end else if (playing) begin
         if (prescale == PRESCALE_LAST) begin
            prescale <= '0;
            if (seconds != 10'd999) seconds <= seconds + 10'd1;
         end else begin
            prescale <= prescale + 1'b1;
         end
      end
   end

   assign bus.elapsed_seconds = seconds;
`else
   logic unused_clk_hz;
   assign unused_clk_hz       = (CLK_HZ > 0);
   assign bus.elapsed_seconds = 10'd0;
`endif

endmodule

// File: tb/tb_game_controller.sv
module tb_game_controller;
   logic       clk;
   logic       reset;
   logic [5:0] btn;   // 0 up, 1 down, 2 left, 3 right, 4 a, 5 b
   int         checks;
   int         errors;

`ifdef GAME_TIMER_EN
   localparam bit TIMER = 1'b1;
`else
   localparam bit TIMER = 1'b0;
`endif

   game_controller_if bus ();

   game_controller #(.LOAD_CYCLES(2), .CLK_HZ(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .up_in    (btn[0]),
      .down_in  (btn[1]),
      .left_in  (btn[2]),
      .right_in (btn[3]),
      .a_in     (btn[4]),
      .b_in     (btn[5]),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic tap(input int b);
      btn[b] = 1'b1;
      @(negedge clk);
      btn[b] = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      btn = 6'b111111;
      tick(3);
      #1;
      checks++; if (bus.current_state !== 3'b000) begin errors++; $display("FAIL reset_state: got %b expected 000", bus.current_state); end
      checks++; if (bus.index !== 7'd0) begin errors++; $display("FAIL reset_index: got %0d expected 0", bus.index); end
      checks++; if (bus.map_select !== 2'd0) begin errors++; $display("FAIL reset_map: got %0d expected 0", bus.map_select); end
      checks++; if (bus.soft_reset !== 1'b0) begin errors++; $display("FAIL reset_soft: got %b expected 0", bus.soft_reset); end
      checks++; if (bus.elapsed_seconds !== 10'd0) begin errors++; $display("FAIL reset_elapsed: got %0d expected 0", bus.elapsed_seconds); end
      checks++; if ({bus.up_pulse, bus.down_pulse, bus.a_pulse, bus.b_pulse} !== 4'b0000) begin errors++; $display("FAIL reset_pulses: got %b expected 0000", {bus.up_pulse, bus.down_pulse, bus.a_pulse, bus.b_pulse}); end
      btn = 6'b0;
      @(negedge clk);
      reset = 1'b0;
      tick(2);
   endtask

   task automatic test_start;
      btn[4] = 1'b1;
      @(negedge clk);
      checks++; if (bus.current_state !== 3'b001) begin errors++; $display("FAIL start_escolher: got %b expected 001", bus.current_state); end
      btn[4] = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_map_select;
      tap(1);
      checks++; if (bus.map_select !== 2'd3) begin errors++; $display("FAIL map_down_wrap: got %0d expected 3", bus.map_select); end
      tap(0);
      tap(0);
      checks++; if (bus.map_select !== 2'd1) begin errors++; $display("FAIL map_up_twice: got %0d expected 1", bus.map_select); end
      btn[0] = 1'b1; btn[1] = 1'b1;
      @(negedge clk);
      btn[0] = 1'b0; btn[1] = 1'b0;
      @(negedge clk);
      checks++; if (bus.map_select !== 2'd2) begin errors++; $display("FAIL map_up_wins: got %0d expected 2", bus.map_select); end
      checks++; if (bus.current_state !== 3'b001) begin errors++; $display("FAIL map_state_hold: got %b expected 001", bus.current_state); end
   endtask

   task automatic test_load;
      btn[4] = 1'b1;
      @(negedge clk);
      checks++; if (bus.current_state !== 3'b010) begin errors++; $display("FAIL load_cycle1: got %b expected 010", bus.current_state); end
      btn[4] = 1'b0;
      @(negedge clk);
      checks++; if (bus.current_state !== 3'b010) begin errors++; $display("FAIL load_cycle2: got %b expected 010", bus.current_state); end
      @(negedge clk);
      checks++; if (bus.current_state !== 3'b011) begin errors++; $display("FAIL load_done: got %b expected 011", bus.current_state); end
      checks++; if (bus.index !== 7'd0) begin errors++; $display("FAIL load_index: got %0d expected 0", bus.index); end
   endtask

   task automatic test_cursor_wrap;
      tap(0);
      checks++; if (bus.index !== 7'd72) begin errors++; $display("FAIL cur_up_wrap: got %0d expected 72", bus.index); end
      tap(2);
      checks++; if (bus.index !== 7'd80) begin errors++; $display("FAIL cur_left_wrap: got %0d expected 80", bus.index); end
      tap(3);
      checks++; if (bus.index !== 7'd72) begin errors++; $display("FAIL cur_right_wrap: got %0d expected 72", bus.index); end
      btn[3] = 1'b1;
      tick(4);
      checks++; if (bus.index !== 7'd73) begin errors++; $display("FAIL cur_held_right: got %0d expected 73", bus.index); end
      btn[3] = 1'b0;
      @(negedge clk);
      tap(1);
      checks++; if (bus.index !== 7'd1) begin errors++; $display("FAIL cur_down_wrap: got %0d expected 1", bus.index); end
      tap(1);
      checks++; if (bus.index !== 7'd10) begin errors++; $display("FAIL cur_down: got %0d expected 10", bus.index); end
   endtask

   task automatic test_cell_entry;
      btn[4] = 1'b1;
      #1;
      checks++; if (bus.a_pulse !== 1'b0) begin errors++; $display("FAIL cell_no_pulse_tab: got %b expected 0", bus.a_pulse); end
      @(negedge clk);
      checks++; if (bus.current_state !== 3'b100) begin errors++; $display("FAIL cell_enter: got %b expected 100", bus.current_state); end
      btn[4] = 1'b0;
      @(negedge clk);
      btn[0] = 1'b1;
      #1;
      checks++; if (bus.up_pulse !== 1'b1) begin errors++; $display("FAIL cell_up_pulse: got %b expected 1", bus.up_pulse); end
      @(negedge clk);
      #1;
      checks++; if (bus.up_pulse !== 1'b0) begin errors++; $display("FAIL cell_up_pulse_once: got %b expected 0", bus.up_pulse); end
      checks++; if (bus.current_state !== 3'b100 || bus.index !== 7'd10) begin errors++; $display("FAIL cell_frozen: got state %b index %0d expected 100 10", bus.current_state, bus.index); end
      btn[0] = 1'b0;
      @(negedge clk);
      btn[4] = 1'b1;
      #1;
      checks++; if (bus.a_pulse !== 1'b1) begin errors++; $display("FAIL cell_a_pulse: got %b expected 1", bus.a_pulse); end
      @(negedge clk);
      #1;
      checks++; if (bus.a_pulse !== 1'b0) begin errors++; $display("FAIL cell_a_pulse_once: got %b expected 0", bus.a_pulse); end
      checks++; if (bus.current_state !== 3'b011) begin errors++; $display("FAIL cell_exit: got %b expected 011", bus.current_state); end
      btn[4] = 1'b0;
      @(negedge clk);
      bus.visibilities[10] = 1'b1;
      tap(4);
      checks++; if (bus.current_state !== 3'b011) begin errors++; $display("FAIL cell_visible_ignored: got %b expected 011", bus.current_state); end
      tap(3);
      tap(4);
      checks++; if (bus.current_state !== 3'b100) begin errors++; $display("FAIL cell_enter_11: got %b expected 100", bus.current_state); end
   endtask

   task automatic test_end_conditions;
      bus.strikes = 2'd3;
      btn[0] = 1'b1;
      #1;
      checks++; if (bus.up_pulse !== 1'b1) begin errors++; $display("FAIL end_up_pulse: got %b expected 1", bus.up_pulse); end
      @(negedge clk);
      checks++; if (bus.current_state !== 3'b110) begin errors++; $display("FAIL end_derrota: got %b expected 110", bus.current_state); end
      btn[0] = 1'b0;
      @(negedge clk);
      btn[4] = 1'b1;
      @(negedge clk);
      checks++; if (bus.current_state !== 3'b000 || bus.soft_reset !== 1'b1) begin errors++; $display("FAIL end_soft_reset: got state %b soft %b expected 000 1", bus.current_state, bus.soft_reset); end
      btn[4] = 1'b0;
      @(negedge clk);
      checks++; if (bus.soft_reset !== 1'b0) begin errors++; $display("FAIL end_soft_one_cycle: got %b expected 0", bus.soft_reset); end
      bus.strikes = 2'd0;
      bus.visibilities = '0;
   endtask

   task automatic test_win_and_timer;
      logic [9:0] exp_sec;
      tap(4);
      btn[4] = 1'b1;
      @(negedge clk);
      checks++; if (bus.current_state !== 3'b010 || bus.elapsed_seconds !== 10'd0) begin errors++; $display("FAIL win_load: got state %b sec %0d expected 010 0", bus.current_state, bus.elapsed_seconds); end
      btn[4] = 1'b0;
      tick(2);
      checks++; if (bus.current_state !== 3'b011) begin errors++; $display("FAIL win_play: got %b expected 011", bus.current_state); end
      tick(11);
      exp_sec = TIMER ? 10'd2 : 10'd0;
      checks++; if (bus.elapsed_seconds !== exp_sec) begin errors++; $display("FAIL timer_11: got %0d expected %0d", bus.elapsed_seconds, exp_sec); end
      tick(1);
      exp_sec = TIMER ? 10'd3 : 10'd0;
      checks++; if (bus.elapsed_seconds !== exp_sec) begin errors++; $display("FAIL timer_12: got %0d expected %0d", bus.elapsed_seconds, exp_sec); end
      bus.visibilities = '1;
      @(negedge clk);
      checks++; if (bus.current_state !== 3'b101) begin errors++; $display("FAIL win_vitoria: got %b expected 101", bus.current_state); end
      tick(5);
      btn[4] = 1'b1;
      @(negedge clk);
      checks++; if (bus.current_state !== 3'b000 || bus.soft_reset !== 1'b1) begin errors++; $display("FAIL win_soft_reset: got state %b soft %b expected 000 1", bus.current_state, bus.soft_reset); end
      btn[4] = 1'b0;
      @(negedge clk);
      checks++; if (bus.soft_reset !== 1'b0) begin errors++; $display("FAIL win_soft_one_cycle: got %b expected 0", bus.soft_reset); end
      bus.visibilities = '0;
      tick(6);
      checks++; if (bus.elapsed_seconds !== exp_sec) begin errors++; $display("FAIL timer_paused: got %0d expected %0d", bus.elapsed_seconds, exp_sec); end
      tap(4);
      btn[4] = 1'b1;
      @(negedge clk);
      checks++; if (bus.current_state !== 3'b010 || bus.elapsed_seconds !== 10'd0) begin errors++; $display("FAIL timer_cleared: got state %b sec %0d expected 010 0", bus.current_state, bus.elapsed_seconds); end
      btn[4] = 1'b0;
   endtask

   task automatic test_reset_mid_op;
      @(negedge clk);
      checks++; if (bus.map_select !== 2'd2) begin errors++; $display("FAIL mid_map_kept: got %0d expected 2", bus.map_select); end
      #2 reset = 1'b1;
      #1;
      checks++; if (bus.current_state !== 3'b000 || bus.map_select !== 2'd0 || bus.index !== 7'd0) begin errors++; $display("FAIL mid_reset: got state %b map %0d index %0d expected 000 0 0", bus.current_state, bus.map_select, bus.index); end
      @(negedge clk);
      reset = 1'b0;
      tick(3);
      checks++; if (bus.current_state !== 3'b000 || bus.soft_reset !== 1'b0) begin errors++; $display("FAIL mid_after: got state %b soft %b expected 000 0", bus.current_state, bus.soft_reset); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      btn = 6'b0;
      reset = 1'b1;
      bus.visibilities = '0;
      bus.strikes = 2'd0;
      test_reset;
      test_start;
      test_map_select;
      test_load;
      test_cursor_wrap;
      test_cell_entry;
      test_end_conditions;
      test_win_and_timer;
      test_reset_mid_op;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/game_controller.md
# game_controller

Top-level game sequencer for the Sudoku core. It owns the game FSM and the board cursor, and edge-detects the player buttons. It drives `current_state`, `index` and the gated button pulses consumed by the board updater, then decides win/loss from the updater's `visibilities` and `strikes`.

## Interface
Parameters:
- `LOAD_CYCLES`, 2: cycles spent in CARREGANDO, covering map-ROM latency plus the updater load edge. Range 1..15.
- `CLK_HZ`, 50_000_000: clock frequency. Used only with `GAME_TIMER_EN`.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `up_in`, `down_in`, `left_in`, `right_in`, `a_in`, `b_in`  in  1 each  synchronized, debounced button levels, active-high.
- `visibilities`  in  81  from updater; bit i set means cell i is revealed.
- `strikes`  in  2  from updater.
- `current_state`  out  3  game state, encoding below.
- `index`  out  7  cursor cell, row*9+col, range 0..80.
- `map_select`  out  2  map chosen for loading.
- `up_pulse`, `down_pulse`, `a_pulse`, `b_pulse`  out  1 each  gated rising-edge pulses to the updater.
- `soft_reset`  out  1  one-cycle pulse; the top level ORs it into the updater reset.
- `elapsed_seconds`  out  10  play time in seconds.

## Operation
- **Edge detect:** `prev_x` registers each button level. `rise_x = x_in & ~prev_x`.
- **Pulse gating:** `x_pulse = rise_x & (current_state == PERCORRER_NUMEROS)`. This is combinational, so the updater samples it on the same edge the FSM acts on it.
- **State encoding:**
  - INICIO 000
  - ESCOLHER_MAPA 001
  - CARREGANDO 010
  - PERCORRER_TABULEIRO 011
  - PERCORRER_NUMEROS 100
  - VITORIA 101
  - DERROTA 110
  - 111 is unused and goes to INICIO.
- **INICIO:** rise_a goes to ESCOLHER_MAPA.
- **ESCOLHER_MAPA:** rise_up increments `map_select` (3 wraps to 0); rise_down decrements it (0 wraps to 3). If both rise together, up wins. rise_a goes to CARREGANDO and clears the load counter.
- **CARREGANDO:** the load counter increments each cycle. After exactly `LOAD_CYCLES` cycles the FSM goes to PERCORRER_TABULEIRO with row = col = 0.
- **PERCORRER_TABULEIRO:** one move per cycle, priority up > down > left > right.
  - up: row-1, wraps 0 to 8. down: row+1, wraps 8 to 0.
  - left/right: col, with the same wrap.
  - rise_a on a hidden cell goes to PERCORRER_NUMEROS. rise_a on a visible cell is ignored. rise_b is ignored.
- **PERCORRER_NUMEROS:** the cursor is frozen. rise_a or rise_b goes to PERCORRER_TABULEIRO; the updater has already sampled the pulse on that same edge. up/down stay in this state.
- **End check:** evaluated every cycle in TABULEIRO and NUMEROS, with priority over button transitions.
  - `strikes == 3` goes to DERROTA.
  - Otherwise `&visibilities` goes to VITORIA.
- **VITORIA / DERROTA:** rise_a goes to INICIO and asserts `soft_reset` for the first cycle in INICIO.
- **`index` and the cursor** are registered. `index` is updated in the same cycle as row/col, and `index = row*9 + col` always holds.

## Timing
- **Reset values:**
  - `current_state` = INICIO, `index` = 0, row = col = 0, `map_select` = 0.
  - `soft_reset` = 0, `elapsed_seconds` = 0, all `prev_x` = 0.
  - Pulses are 0 because they are combinational from `prev_x` and state.
- **Pulse timing:** a button held high produces one `rise_x` in the first cycle after it goes high. Holding it produces no repeat.
- **State latency:** a state change is visible one cycle after the sampling edge.
- **CARREGANDO duration:** `current_state` = 010 for exactly `LOAD_CYCLES` consecutive cycles.
- **Reset mid-operation:** all registers return to reset values immediately; no pulse is emitted.

## Configuration
- `GAME_TIMER_EN` defined:
  - A prescaler counts `CLK_HZ` cycles while in TABULEIRO or NUMEROS. It pauses in every other state.
  - Each wrap increments `elapsed_seconds`, which saturates at 999.
  - Entering CARREGANDO clears both the prescaler and `elapsed_seconds`.
- `GAME_TIMER_EN` undefined: the prescaler is not built and `elapsed_seconds` is tied to 0. All other behaviour is identical.

## Test plan
- **Reset/start:** release reset, then a, a → states 000, 001, 010. With `LOAD_CYCLES`=2, state is 010 for 2 cycles, then 011 with `index`=0.
- **Map select:** in ESCOLHER_MAPA, down once → `map_select`=3. Then up twice → 1. Up and down rising together → up wins.
- **Cursor wrap:** at index 0, up → 72. Then left → 80. Then right → 72. A held right moves exactly once.
- **Cell entry and pulses:** a on hidden cell 10 → state 100. In state 100, up produces `up_pulse` for 1 cycle. Then a → `a_pulse` for 1 cycle and state 011. With `visibilities` bit 10 set, a at index 10 stays in 011.
- **End conditions:** drive `strikes`=3 in 100 together with rise_up → DERROTA wins, state 110. Drive `visibilities` all ones → 101. Then a → 000 with `soft_reset` high for exactly 1 cycle.
- **Timer (`GAME_TIMER_EN`, `CLK_HZ`=4):** 12 cycles in 011 → `elapsed_seconds`=3. Time in 000 does not advance it. Re-entering CARREGANDO → 0.
